// File: rtl/risc_exec_unit_pkg.sv
// Shared types for the VeriRISC execution core: opcode and FSM state
// encodings, default widths, and the ALU-opcode classifier.
package risc_exec_unit_pkg;

  localparam int unsigned DWIDTH_DEF = 8;
  localparam int unsigned AWIDTH_DEF = 5;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  // Opcodes that read an operand from memory and write the accumulator
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_exec_unit_alu.sv
// Accumulator ALU with zero flag.
// Build option: ALU_OUT_REG_EN registers alu_out (one-cycle latency, reset
// to 0); otherwise alu_out is combinational. zero is always combinational.
// Ports: clk/rst_ (registered build only), opcode, accum, data -> alu_out, zero.
import risc_exec_unit_pkg::*;

module exec_alu #(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
`ifdef ALU_OUT_REG_EN
  input  logic              clk,
  input  logic              rst_,
`endif
  input  opcode_t           opcode,
  input  logic [DWIDTH-1:0] accum,
  input  logic [DWIDTH-1:0] data,
  output logic [DWIDTH-1:0] alu_out,
  output logic              zero
);

  logic [DWIDTH-1:0] alu_comb;

  // Result selection; carry out of ADD is dropped
  always_comb begin
    alu_comb = accum;
    case (opcode)
      ADD:     alu_comb = DWIDTH'(accum + data);
      AND:     alu_comb = accum & data;
      XOR:     alu_comb = accum ^ data;
      LDA:     alu_comb = data;
      default: alu_comb = accum;
    endcase
  end

  assign zero = (accum == '0);

`ifdef ALU_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) alu_out <= '0;
    else       alu_out <= alu_comb;
  end
`else
  assign alu_out = alu_comb;
`endif

endmodule

// File: rtl/risc_exec_unit.sv
// VeriRISC execution core: 8-state sequencing FSM, loadable program counter
// and accumulator ALU (exec_alu).
// Build option: ALU_OUT_REG_EN (see exec_alu).
// Ports: clk, rst_ (async active-low); opcode, ir_addr from the IR; accum,
// data operands; alu_out, zero, pc_addr; control strobes mem_rd, mem_wr,
// load_ir, load_ac, load_pc, inc_pc, halt (combinational from state/opcode).
import risc_exec_unit_pkg::*;

module risc_exec_unit #(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [2:0]        opcode,
  input  logic [AWIDTH-1:0] ir_addr,
  input  logic [DWIDTH-1:0] accum,
  input  logic [DWIDTH-1:0] data,
  output logic [DWIDTH-1:0] alu_out,
  output logic              zero,
  output logic [AWIDTH-1:0] pc_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              load_ir,
  output logic              load_ac,
  output logic              load_pc,
  output logic              inc_pc,
  output logic              halt
);

  state_t  state, next_state;
  opcode_t op;
  logic    aluop;

  assign op    = opcode_t'(opcode);
  assign aluop = is_aluop(op);

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= INST_ADDR;
    else       state <= next_state;
  end

  // Free-running sequence and per-state strobe decode
  always_comb begin
    next_state = INST_ADDR;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    load_ir    = 1'b0;
    load_ac    = 1'b0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    halt       = 1'b0;
    case (state)
      INST_ADDR:  next_state = INST_FETCH;
      INST_FETCH: begin
        next_state = INST_LOAD;
        mem_rd     = 1'b1;
      end
      INST_LOAD: begin
        next_state = IDLE;
        mem_rd     = 1'b1;
        load_ir    = 1'b1;
      end
      IDLE: begin
        next_state = OP_ADDR;
        mem_rd     = 1'b1;
        load_ir    = 1'b1;
      end
      OP_ADDR: begin
        next_state = OP_FETCH;
        inc_pc     = 1'b1;
        halt       = (op == HLT);
      end
      OP_FETCH: begin
        next_state = ALU_OP;
        mem_rd     = aluop;
      end
      ALU_OP: begin
        next_state = STORE;
        mem_rd     = aluop;
        inc_pc     = (op == SKZ) && zero;
        load_pc    = (op == JMP);
      end
      STORE: begin
        next_state = INST_ADDR;
        mem_rd     = aluop;
        load_ac    = aluop;
        inc_pc     = (op == JMP);
        load_pc    = (op == JMP);
        mem_wr     = (op == STO);
      end
    endcase
  end

  // Program counter: a jump load wins over increment
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)       pc_addr <= '0;
    else if (load_pc) pc_addr <= ir_addr;
    else if (inc_pc)  pc_addr <= pc_addr + AWIDTH'(1);
  end

  exec_alu #(.DWIDTH(DWIDTH)) u_alu (
`ifdef ALU_OUT_REG_EN
    .clk     (clk),
    .rst_    (rst_),
`endif
    .opcode  (op),
    .accum   (accum),
    .data    (data),
    .alu_out (alu_out),
    .zero    (zero)
  );

endmodule

// File: tb/tb_risc_exec_unit.sv
// Directed self-checking bench for risc_exec_unit.
import risc_exec_unit_pkg::*;

module tb_risc_exec_unit;

  logic       clk = 1'b0;
  logic       rst_;
  logic [2:0] opcode;
  logic [4:0] ir_addr;
  logic [7:0] accum, data, alu_out;
  logic       zero;
  logic [4:0] pc_addr;
  logic       mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
  logic [6:0] strobes;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign strobes = {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt};

  risc_exec_unit dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .ir_addr(ir_addr),
    .accum(accum), .data(data), .alu_out(alu_out), .zero(zero),
    .pc_addr(pc_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
    .load_ac(load_ac), .load_pc(load_pc), .inc_pc(inc_pc), .halt(halt)
  );

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the core in INST_ADDR with pc=0 at a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    cycle(2);
    rst_ = 1'b1;
  endtask

  // From INST_ADDR, executes one JMP so pc ends at a, back in INST_ADDR
  task automatic set_pc(input logic [4:0] a);
    opcode  = JMP;
    ir_addr = a;
    cycle(8);
  endtask

  task automatic test_reset();
    logic [6:0] exp [8];
    exp = '{7'b0000000, 7'b1000000, 7'b1010000, 7'b1010000,
            7'b0000010, 7'b1000000, 7'b1000000, 7'b1001000};
    opcode = ADD; ir_addr = 5'h11; accum = 8'h10; data = 8'h01;
    do_reset();
    total++;
    if (dut.state !== INST_ADDR) begin
      bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, INST_ADDR);
    end
    total++;
    if (pc_addr !== 5'd0) begin
      bad++; $display("FAIL reset_pc got=%0d exp=0", pc_addr);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (strobes !== exp[i]) begin
        bad++; $display("FAIL add_strobes st=%0d got=%b exp=%b", i, strobes, exp[i]);
      end
      cycle(1);
    end
    total++;
    if (dut.state !== INST_ADDR || pc_addr !== 5'd1) begin
      bad++; $display("FAIL wrap_state_pc st=%0d pc=%0d exp st=0 pc=1", dut.state, pc_addr);
    end
  endtask

  task automatic test_alu();
    logic [2:0] ops [10];
    logic [7:0] a   [10];
    logic [7:0] d   [10];
    logic [7:0] exp [10];
    ops = '{HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP, ADD, XOR};
    a   = '{8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF, 8'hFF};
    d   = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h01, 8'h0F};
    exp = '{8'hC3, 8'hC3, 8'h18, 8'h41, 8'h96, 8'h55, 8'hC3, 8'hC3, 8'h00, 8'hF0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      opcode = ops[i]; accum = a[i]; data = d[i];
`ifdef ALU_OUT_REG_EN
      @(negedge clk);
`else
      #1;
`endif
      total++;
      if (alu_out !== exp[i]) begin
        bad++; $display("FAIL alu op=%0d a=%h d=%h got=%h exp=%h", ops[i], a[i], d[i], alu_out, exp[i]);
      end
    end
    accum = 8'h00; #1;
    total++;
    if (zero !== 1'b1) begin
      bad++; $display("FAIL zero_at_0 got=%b exp=1", zero);
    end
    accum = 8'h01; #1;
    total++;
    if (zero !== 1'b0) begin
      bad++; $display("FAIL zero_at_1 got=%b exp=0", zero);
    end
    accum = 8'h80; #1;
    total++;
    if (zero !== 1'b0) begin
      bad++; $display("FAIL zero_at_80 got=%b exp=0", zero);
    end
  endtask

  task automatic test_skz();
    do_reset();
    set_pc(5'd5);
    opcode = SKZ; accum = 8'h00;
    cycle(8);
    total++;
    if (pc_addr !== 5'd7) begin
      bad++; $display("FAIL skz_taken got=%0d exp=7", pc_addr);
    end
    do_reset();
    set_pc(5'd5);
    opcode = SKZ; accum = 8'h01;
    cycle(8);
    total++;
    if (pc_addr !== 5'd6) begin
      bad++; $display("FAIL skz_not_taken got=%0d exp=6", pc_addr);
    end
  endtask

  task automatic test_jmp_hlt();
    do_reset();
    opcode = JMP; ir_addr = 5'h1A;
    cycle(7);
    total++;
    if (strobes !== 7'b0000110) begin
      bad++; $display("FAIL jmp_store_strobes got=%b exp=0000110", strobes);
    end
    cycle(1);
    total++;
    if (pc_addr !== 5'h1A) begin
      bad++; $display("FAIL jmp_pc got=%h exp=1a", pc_addr);
    end
    do_reset();
    opcode = HLT;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (halt !== (i == 4)) begin
        bad++; $display("FAIL hlt_halt st=%0d got=%b exp=%b", i, halt, (i == 4));
      end
      cycle(1);
    end
    total++;
    if (pc_addr !== 5'd1) begin
      bad++; $display("FAIL hlt_pc got=%0d exp=1", pc_addr);
    end
  endtask

  task automatic test_sto_wrap();
    logic [6:0] exp [8];
    exp = '{7'b0000000, 7'b1000000, 7'b1010000, 7'b1010000,
            7'b0000010, 7'b0000000, 7'b0000000, 7'b0100000};
    do_reset();
    opcode = STO;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (strobes !== exp[i]) begin
        bad++; $display("FAIL sto_strobes st=%0d got=%b exp=%b", i, strobes, exp[i]);
      end
      cycle(1);
    end
    do_reset();
    set_pc(5'd31);
    opcode = ADD;
    cycle(8);
    total++;
    if (pc_addr !== 5'd0) begin
      bad++; $display("FAIL pc_wrap got=%0d exp=0", pc_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    opcode = ADD; accum = 8'h12; data = 8'h34;
    cycle(6);
    total++;
    if (dut.state !== ALU_OP || mem_rd !== 1'b1 || pc_addr !== 5'd1) begin
      bad++; $display("FAIL pre_abort st=%0d mem_rd=%b pc=%0d exp st=6 rd=1 pc=1", dut.state, mem_rd, pc_addr);
    end
    #2 rst_ = 1'b0;
    #1;
    total++;
    if (dut.state !== INST_ADDR || pc_addr !== 5'd0 || strobes !== 7'b0) begin
      bad++; $display("FAIL async_reset st=%0d pc=%0d strobes=%b exp 0/0/0", dut.state, pc_addr, strobes);
    end
`ifdef ALU_OUT_REG_EN
    total++;
    if (alu_out !== 8'h00) begin
      bad++; $display("FAIL async_reset_alu got=%h exp=00", alu_out);
    end
`endif
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    rst_ = 1'b0; opcode = HLT; ir_addr = '0; accum = '0; data = '0;
    test_reset();
    test_alu();
    test_skz();
    test_jmp_hlt();
    test_sto_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
